booth4_mult_seq: RTL and testbench

BOOTH4_MULT_SEQ -- requirements
Module: booth4_mult_seq

---
 rtl/booth4_mult_seq.sv | 111 +++++++++++
 tb/tb_booth4_mult_seq.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/booth4_mult_seq.sv
// booth4_mult_seq: sequential radix-4 Booth multiplier, signed/unsigned, one Booth digit per clock
//   clock/clear_n      : rising-edge clock, asynchronous active-low reset
//   start              : accept operands (in IDLE or DONE)
//   signed_mode        : 1 = two's complement operands, 0 = unsigned
//   operandA/operandB  : multiplicand / multiplier
//   busy               : multiply in flight (RUN)
//   result_rdy         : one-cycle pulse in DONE
//   product            : full 2*WIDTH-bit product, held until next DONE
//   mult_result        : low WIDTH bits of product
//   mult_exception     : product does not fit in WIDTH bits for the selected mode
module booth4_mult_seq #(
  parameter int WIDTH = 32
) (
  input  logic               clock,
  input  logic               clear_n,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   operandA,
  input  logic [WIDTH-1:0]   operandB,
  output logic               busy,
  output logic               result_rdy,
  output logic [2*WIDTH-1:0] product,
  output logic [WIDTH-1:0]   mult_result,
  output logic               mult_exception
);
  localparam int N  = WIDTH / 2 + 1;
  localparam int CW = $clog2(N + 1);
  localparam int EW = WIDTH + 2;
  localparam int AW = WIDTH + 3;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t              state_q;
  logic [CW-1:0]       cnt_q;
  logic [AW-1:0]       m_q, acc_q;
  logic [EW-1:0]       mul_q;
  logic                bm1_q, sgn_q, busy_q, rdy_q, exc_q;
  logic [2*WIDTH-1:0]  product_q;
  logic [AW-1:0]       ext_a, pp_d, sum_d;
  logic [EW-1:0]       ext_b;
  logic [2:0]          trip;
  logic [AW+EW-1:0]    shr_d;
  logic [2*WIDTH-1:0]  prod_d;
  logic [WIDTH:0]      top_d;
  logic                exc_d;
  always_comb begin
    ext_a  = {{3{signed_mode & operandA[WIDTH-1]}}, operandA};
    ext_b  = {{2{signed_mode & operandB[WIDTH-1]}}, operandB};
    trip   = {mul_q[1:0], bm1_q};
    pp_d   = (trip == 3'b001 || trip == 3'b010) ? m_q :
             (trip == 3'b011) ? m_q << 1 :
             (trip == 3'b100) ? -(m_q << 1) :
             (trip == 3'b101 || trip == 3'b110) ? -m_q : '0;
    sum_d  = acc_q + pp_d;
    // {acc, multiplier} shift together; after N steps the pair holds the full product
    shr_d  = $signed({sum_d, mul_q}) >>> 2;
    prod_d = shr_d[2*WIDTH-1:0];
    top_d  = prod_d[2*WIDTH-1:WIDTH-1];
    exc_d  = sgn_q ? ~(&top_d | ~|top_d) : |prod_d[2*WIDTH-1:WIDTH];
  end
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      m_q       <= '0;
      acc_q     <= '0;
      mul_q     <= '0;
      bm1_q     <= 1'b0;
      sgn_q     <= 1'b0;
      busy_q    <= 1'b0;
      rdy_q     <= 1'b0;
      exc_q     <= 1'b0;
      product_q <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          rdy_q <= 1'b0;
          if (start) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            m_q     <= ext_a;
            acc_q   <= '0;
            mul_q   <= ext_b;
            bm1_q   <= 1'b0;
            sgn_q   <= signed_mode;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          acc_q <= shr_d[AW+EW-1:EW];
          mul_q <= shr_d[EW-1:0];
          bm1_q <= mul_q[1];
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(N - 1)) begin
            state_q   <= DONE;
            busy_q    <= 1'b0;
            rdy_q     <= 1'b1;
            product_q <= prod_d;
            exc_q     <= exc_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign busy           = busy_q;
  assign result_rdy     = rdy_q;
  assign product        = product_q;
  assign mult_result    = product_q[WIDTH-1:0];
  assign mult_exception = exc_q;
endmodule

// File: tb/tb_booth4_mult_seq.sv
// tb_booth4_mult_seq: scoreboard bench for booth4_mult_seq at WIDTH=32 and WIDTH=8
module tb_booth4_mult_seq;
  logic clock = 1'b0;
  logic clear_n = 1'b0;
  always #5 clock = ~clock;
  typedef struct {
    logic [63:0] p;
    logic        e;
    int          acc;
  } exp_t;
  exp_t q32[$];
  exp_t q8[$];
  exp_t e32, e8;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [63:0] last_p32;
  always @(posedge clock) cyc <= cyc + 1;
  logic        s32 = 0, sm32 = 0, busy32, rdy32, exc32;
  logic [31:0] a32 = 0, b32 = 0, res32;
  logic [63:0] prod32;
  logic        s8 = 0, sm8 = 0, busy8, rdy8, exc8;
  logic [7:0]  a8 = 0, b8 = 0, res8;
  logic [15:0] prod8;
  booth4_mult_seq #(.WIDTH(32)) dut32 (
    .clock(clock), .clear_n(clear_n), .start(s32), .signed_mode(sm32),
    .operandA(a32), .operandB(b32), .busy(busy32), .result_rdy(rdy32),
    .product(prod32), .mult_result(res32), .mult_exception(exc32));
  booth4_mult_seq #(.WIDTH(8)) dut8 (
    .clock(clock), .clear_n(clear_n), .start(s8), .signed_mode(sm8),
    .operandA(a8), .operandB(b8), .busy(busy8), .result_rdy(rdy8),
    .product(prod8), .mult_result(res8), .mult_exception(exc8));
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  // Reference: interpret operands as integers for the mode, multiply, judge range
  function automatic exp_t model(input int w, input logic [31:0] a, input logic [31:0] b, input logic sm);
    exp_t r;
    longint va, vb, lim, ps;
    logic [63:0] pu;
    va = longint'({32'b0, a} & ((64'd1 << w) - 1));
    vb = longint'({32'b0, b} & ((64'd1 << w) - 1));
    if (sm && a[w-1]) va -= longint'(1) << w;
    if (sm && b[w-1]) vb -= longint'(1) << w;
    ps  = va * vb;
    pu  = 64'(ps);
    lim = longint'(1) << (w - 1);
    r.p = (w == 32) ? pu : pu & ((64'd1 << (2 * w)) - 1);
    r.e = sm ? (ps < -lim || ps >= lim) : (pu >= (64'd1 << w));
    r.acc = 0;
    return r;
  endfunction
  always @(negedge clock) begin
    if (clear_n && rdy32) begin
      if (q32.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rdy32_unexpected: got pulse expected none");
      end else begin
        e32 = q32.pop_front();
        chk("prod32", prod32, e32.p);
        chk("res32", {32'b0, res32}, {32'b0, e32.p[31:0]});
        chk("exc32", {63'b0, exc32}, {63'b0, e32.e});
        chk("lat32", 64'(cyc - e32.acc), 64'd17);
        chk("busy32_done", {63'b0, busy32}, 64'd0);
      end
    end
    if (clear_n && rdy8) begin
      if (q8.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rdy8_unexpected: got pulse expected none");
      end else begin
        e8 = q8.pop_front();
        chk("prod8", {48'b0, prod8}, e8.p);
        chk("res8", {56'b0, res8}, {56'b0, e8.p[7:0]});
        chk("exc8", {63'b0, exc8}, {63'b0, e8.e});
        chk("lat8", 64'(cyc - e8.acc), 64'd5);
      end
    end
  end
  task automatic issue32(input logic [31:0] a, input logic [31:0] b, input logic sm, input bit hold);
    exp_t x;
    s32 = 1; a32 = a; b32 = b; sm32 = sm;
    @(posedge clock); #1;
    x = model(32, a, b, sm);
    x.acc = cyc;
    last_p32 = x.p;
    q32.push_back(x);
    chk("busy32_run", {63'b0, busy32}, 64'd1);
    s32 = hold; a32 = $urandom; b32 = $urandom; sm32 = 1'($urandom);
  endtask
  task automatic wait32();
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (rdy32) return;
    end
    checks++;
    errors++;
    $display("FAIL timeout32: got no result_rdy expected pulse");
  endtask
  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic sm);
    exp_t x;
    s8 = 1; a8 = a; b8 = b; sm8 = sm;
    @(posedge clock); #1;
    x = model(8, {24'b0, a}, {24'b0, b}, sm);
    x.acc = cyc;
    q8.push_back(x);
    s8 = 0; a8 = 8'($urandom); b8 = 8'($urandom); sm8 = 1'($urandom);
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (rdy8) return;
    end
    checks++;
    errors++;
    $display("FAIL timeout8: got no result_rdy expected pulse");
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, {63'b0, busy32}, 64'd0);
    chk({tag, "_rdy"}, {63'b0, rdy32}, 64'd0);
    chk({tag, "_prod"}, prod32, 64'd0);
    chk({tag, "_res"}, {32'b0, res32}, 64'd0);
    chk({tag, "_exc"}, {63'b0, exc32}, 64'd0);
    chk({tag, "_prod8"}, {48'b0, prod8}, 64'd0);
  endtask
  logic [31:0] da[6] = '{32'h3, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h0};
  logic [31:0] db[6] = '{32'hFFFFFFFC, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h80000000};
  logic        dm[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
  logic [31:0] edge_v[5] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};
  initial begin
    repeat (3) @(negedge clock);
    chk_zero("reset");
    clear_n = 1;
    for (int i = 0; i < 6; i++) begin
      issue32(da[i], db[i], dm[i], 0);
      wait32();
      repeat (2) @(negedge clock);
      chk("hold32", prod32, last_p32);
    end
    issue32(32'd12345, 32'hFFFF0001, 1, 0);
    repeat (3) @(negedge clock);
    s32 = 1;
    @(negedge clock);
    s32 = 0;
    wait32();
    @(negedge clock);
    chk("idle32_busy", {63'b0, busy32}, 64'd0);
    chk("idle32_rdy", {63'b0, rdy32}, 64'd0);
    issue32($urandom, $urandom, 1, 1);
    for (int k = 0; k < 4; k++) begin
      wait32();
      issue32($urandom, $urandom, 1'($urandom), k < 3);
    end
    wait32();
    for (int k = 0; k < 40; k++) begin
      logic [31:0] a, b;
      a = ($urandom_range(0, 3) == 0) ? edge_v[$urandom_range(0, 4)] : $urandom;
      b = ($urandom_range(0, 3) == 0) ? edge_v[$urandom_range(0, 4)] : $urandom;
      repeat ($urandom_range(0, 2)) @(negedge clock);
      issue32(a, b, 1'($urandom), 0);
      wait32();
    end
    @(negedge clock);
    issue32($urandom, $urandom, 1, 0);
    repeat (5) @(posedge clock);
    #2 clear_n = 0;
    #1 chk_zero("midrst");
    q32.delete();
    @(posedge clock); #1;
    chk_zero("midrst_hold");
    @(negedge clock);
    clear_n = 1;
    issue32(32'hFFFFFFF9, 32'd6, 1, 0);
    wait32();
    for (int k = 0; k < 60; k++) begin
      repeat ($urandom_range(0, 1)) @(negedge clock);
      issue8(8'($urandom), 8'($urandom), 1'($urandom));
    end
    issue8(8'h80, 8'hFF, 1);
    issue8(8'hFF, 8'hFF, 0);
    issue8(8'h00, 8'h80, 1);
    repeat (3) @(negedge clock);
    chk("drain32", 64'(q32.size()), 64'd0);
    chk("drain8", 64'(q8.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
